// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: ALU op encoding, instruction classes and branch funct3 codes.
// The alu_op_t encoding is {funct7b5, funct3} so decode can pass instruction bits straight through.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_SRA  = 4'd13
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_OP     = 3'd0,
    CLS_OP_IMM = 3'd1,
    CLS_LUI    = 3'd2,
    CLS_AUIPC  = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_MEM    = 3'd5,
    CLS_BRANCH = 3'd6,
    CLS_RSVD   = 3'd7
  } instr_class_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7b5 only selects SUB/SRA; for every other funct3 it is a don't-care.
  function automatic alu_op_t derive_alu_op(input instr_class_t cls, input logic [2:0] f3,
                                            input logic f7b5);
    alu_op_t op;
    op = ALU_ADD;
    case (cls)
      CLS_OP:     op = (f3 == 3'b000 || f3 == 3'b101) ? alu_op_t'({f7b5, f3})
                                                       : alu_op_t'({1'b0, f3});
      CLS_OP_IMM: op = (f3 == 3'b101) ? alu_op_t'({f7b5, f3}) : alu_op_t'({1'b0, f3});
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator (rs1/rs2/funct3 -> taken).
// Only compiled when BRANCH_CMP_EN is defined; funct3 010/011 are never taken.
`ifdef BRANCH_CMP_EN
module branch_cmp
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) < $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 < rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/alu_operand_stage.sv
// Execute-stage front end: latches a decoded instruction, drives ALU op/operands, captures the result.
// Optional branch comparator enabled by defining BRANCH_CMP_EN; otherwise out_taken is tied low.
module alu_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int LINK_OFFSET = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_class,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output alu_op_t         alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_rs2,
  output logic            out_taken
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic            accept, capture;
  instr_class_t    in_cls;
  alu_op_t         op_next;
  logic [XLEN-1:0] a_next, b_next;

  assign in_cls = instr_class_t'(in_class);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Flush overrides everything below it: no accept, no capture, back to IDLE.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        capture    = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
      accept     = 1'b0;
      capture    = 1'b0;
    end
  end

  always_comb begin
    op_next = derive_alu_op(in_cls, in_funct3, in_funct7b5);
    a_next  = '0;
    b_next  = '0;
    case (in_cls)
      CLS_OP:                 begin a_next = in_rs1; b_next = in_rs2; end
      CLS_OP_IMM, CLS_MEM:    begin a_next = in_rs1; b_next = in_imm; end
      CLS_LUI:                b_next = in_imm;
      CLS_AUIPC, CLS_BRANCH:  begin a_next = in_pc;  b_next = in_imm; end
      CLS_JUMP:               begin a_next = in_pc;  b_next = XLEN'(LINK_OFFSET); end
      default:                ; // reserved class: 0 + 0
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op     <= ALU_ADD;
      alu_a      <= '0;
      alu_b      <= '0;
      out_rs2    <= '0;
      out_result <= '0;
    end else begin
      if (accept) begin
        alu_op  <= op_next;
        alu_a   <= a_next;
        alu_b   <= b_next;
        out_rs2 <= in_rs2;
      end
      if (capture) out_result <= alu_out;
    end
  end

`ifdef BRANCH_CMP_EN
  // alu_a carries pc for branches, so rs1 needs its own copy for the compare.
  logic [XLEN-1:0] rs1_reg;
  logic [2:0]      funct3_reg;
  logic            is_branch_reg;
  logic            cmp_taken;

  branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .rs1    (rs1_reg),
    .rs2    (out_rs2),
    .funct3 (funct3_reg),
    .taken  (cmp_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_reg       <= '0;
      funct3_reg    <= '0;
      is_branch_reg <= 1'b0;
      out_taken     <= 1'b0;
    end else begin
      if (accept) begin
        rs1_reg       <= in_rs1;
        funct3_reg    <= in_funct3;
        is_branch_reg <= (in_cls == CLS_BRANCH);
      end
      if (capture) out_taken <= is_branch_reg & cmp_taken;
    end
  end
`else
  assign out_taken = 1'b0;
`endif

endmodule
